// File: rtl/pll_loop_filter.sv
// PI loop filter: integrates synchronized up/dn steps per UPDATE_DIV window and drives a saturated 16-bit DAC code.
// Latency 2 sync + 2 pipeline clk after the window ends; no backpressure. Optional lock detect under LOOP_LOCK_DETECT_EN.
module pll_loop_filter #(
  parameter int          UPDATE_DIV = 64,
  parameter int          KP_SHIFT   = 4,
  parameter int          KI_SHIFT   = 0,
  parameter int          INT_W      = 24,
  parameter logic [15:0] OFFSET     = 16'h8000,
  parameter int          LOCK_TOL   = 2,
  parameter int          LOCK_CNT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        dn,
  output logic [15:0] dac_word,
  output logic        dac_upd,
  output logic        lock
);

  localparam int CNT_W = $clog2(UPDATE_DIV);
  localparam int ACC_W = CNT_W + 2;
  localparam int SW    = INT_W + 2;

  localparam logic signed [SW-1:0] INT_MAX = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] INT_MIN = {3'b111, {(INT_W-1){1'b0}}};
  localparam logic signed [SW-1:0] DAC_MAX = {{(SW-16){1'b0}}, 16'hFFFF};
  localparam logic signed [SW-1:0] OFF_EXT = {{(SW-16){1'b0}}, OFFSET};

  logic                    up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, err_q, err_d;
  logic                    c1_q, c1_d, c2_q, c2_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic [15:0]             dac_q, dac_d;
  logic                    upd_q, upd_d;

  logic signed [ACC_W-1:0] step, acc_sum;
  logic signed [SW-1:0]    err_ext, integ_ext, integ_sum, integ_sat, dac_sum;
  logic [15:0]             dac_clamp;

  always_comb begin
    step = '0;
    if (up_s2_q && !dn_s2_q) begin
      step = {{(ACC_W-1){1'b0}}, 1'b1};
    end else if (dn_s2_q && !up_s2_q) begin
      step = '1;
    end
    acc_sum = acc_q + step;

    cnt_d = cnt_q;
    acc_d = acc_q;
    err_d = err_q;
    c1_d  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (cnt_q == CNT_W'(UPDATE_DIV - 1)) begin
      cnt_d = '0;
      acc_d = '0;
      err_d = acc_sum;
      c1_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      acc_d = acc_sum;
    end

    err_ext   = {{(SW-ACC_W){err_q[ACC_W-1]}}, err_q};
    integ_ext = {{2{integ_q[INT_W-1]}}, integ_q};

    // Integrator saturates instead of wrapping so a long one-sided run cannot flip the code.
    integ_sum = integ_ext + (err_ext <<< KI_SHIFT);
    integ_sat = integ_sum;
    if (integ_sum > INT_MAX) begin
      integ_sat = INT_MAX;
    end else if (integ_sum < INT_MIN) begin
      integ_sat = INT_MIN;
    end
    integ_d = c1_q ? integ_sat[INT_W-1:0] : integ_q;
    c2_d    = c1_q;

    dac_sum   = integ_ext + (err_ext <<< KP_SHIFT) + OFF_EXT;
    dac_clamp = dac_sum[15:0];
    if (dac_sum[SW-1]) begin
      dac_clamp = 16'h0000;
    end else if (dac_sum > DAC_MAX) begin
      dac_clamp = 16'hFFFF;
    end
    dac_d = c2_q ? dac_clamp : dac_q;
    upd_d = c2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_s1_q <= 1'b0;
      up_s2_q <= 1'b0;
      dn_s1_q <= 1'b0;
      dn_s2_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      integ_q <= '0;
      dac_q   <= OFFSET;
      upd_q   <= 1'b0;
    end else begin
      up_s1_q <= up;
      up_s2_q <= up_s1_q;
      dn_s1_q <= dn;
      dn_s2_q <= dn_s1_q;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      integ_q <= integ_d;
      dac_q   <= dac_d;
      upd_q   <= upd_d;
    end
  end

  assign dac_word = dac_q;
  assign dac_upd  = upd_q;

`ifdef LOOP_LOCK_DETECT_EN
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic signed [ACC_W-1:0] TOL_P = ACC_W'(LOCK_TOL);
  localparam logic signed [ACC_W-1:0] TOL_N = -TOL_P;

  logic [RUN_W-1:0] run_q, run_d;
  logic             in_tol;

  always_comb begin
    in_tol = (err_q <= TOL_P) && (err_q >= TOL_N);
    run_d  = run_q;
    if (!en) begin
      run_d = '0;
    end else if (c1_q) begin
      if (!in_tol) begin
        run_d = '0;
      end else if (run_q != RUN_W'(LOCK_CNT)) begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign lock = (run_q == RUN_W'(LOCK_CNT));
`else
  assign lock = 1'b0;
`endif

endmodule

// File: doc/pll_loop_filter.md
Name: pll_loop_filter

Overview:
- Digital PI loop filter for the PLL; sits directly upstream of the serial DAC controller and drives its 16-bit parallel input word.
- Integrates phase-detector up/dn levels over fixed windows and computes a saturated 16-bit DAC code once per window.
- Holds the code stable between updates so each serial DAC frame (CS low, 16 bits, CS high) completes before the word changes.

Parameters:
- UPDATE_DIV, 64, clocks per update window; must be at least 20 to cover one DAC frame plus margin.
- KP_SHIFT, 4, proportional gain as a left shift of the window error.
- KI_SHIFT, 0, integral gain as a left shift of the window error.
- INT_W, 24, integrator width in bits, signed.
- OFFSET, 16'h8000, DAC code at zero integrator, i.e. mid-scale.
- LOCK_TOL, 2, maximum |window error| counted as a locked window (LOOP_LOCK_DETECT_EN only).
- LOCK_CNT, 8, consecutive locked windows required to assert lock (LOOP_LOCK_DETECT_EN only).

Ports:
- clk  in  1  system clock; the same clock as the DAC controller.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  loop enable; level-sensitive.
- up  in  1  phase-detector "up" pulse; asynchronous to clk.
- dn  in  1  phase-detector "down" pulse; asynchronous to clk.
- dac_word  out  16  DAC code; connects to the DAC controller data_in.
- dac_upd  out  1  one-cycle strobe, high in the cycle dac_word takes a new value.
- lock  out  1  lock indicator (LOOP_LOCK_DETECT_EN only).

Behaviour:
- Reset (rst low, asynchronous): dac_word=OFFSET, dac_upd=0, lock=0, integrator=0, window counter=0, error accumulator=0, synchronizers=0.
- Input capture: up and dn each pass through a 2-flop synchronizer (2 clk latency). Each clk, the synchronized pair maps to a step: up&!dn=+1, dn&!up=-1, both or neither=0.
- Windowing:
  - A counter runs 0..UPDATE_DIV-1 while en=1.
  - A signed accumulator, clog2(UPDATE_DIV)+2 bits wide, sums the steps and cannot overflow.
  - At count UPDATE_DIV-1 the final step is included, the sum is latched into err_l, the accumulator clears, and the counter wraps to 0. There is no dead cycle; the next window starts immediately.
- Pipeline, in cycles after the window's last sample:
  - C1: integ <= sat_INT_W(integ + (err_l<<KI_SHIFT)). Clamp range is [-2^(INT_W-1), 2^(INT_W-1)-1]; never wrap.
  - C2: sum = integ + (err_l<<KP_SHIFT) + OFFSET, computed at INT_W+2 bits signed. dac_word <= clamp(sum, 0, 65535). dac_upd=1 for exactly this cycle.
  - dac_upd pulses once per window even when the code is unchanged.
  - dac_word changes only in a dac_upd cycle.
- en deassert:
  - Counter and accumulator clear; partial window is discarded; in-flight C1/C2 still complete.
  - integ and dac_word hold; dac_upd stays low afterwards.
- en reassert: a new window starts at count 0, and the integrator resumes from its held value.
- Simultaneous up and dn high contributes 0.
- Reset mid-window or mid-pipeline: immediate return to reset values; no dac_upd is generated.

Optional Feature:
- Macro: LOOP_LOCK_DETECT_EN.
- When defined:
  - At each C1, if |err_l| <= LOCK_TOL, a saturating run counter increments; otherwise it clears to 0 and lock drops in the next cycle.
  - lock=1 once the run counter reaches LOCK_CNT.
  - en=0 clears the run counter and lock.
- When undefined: lock is tied to 0 and no run counter is built.

Test Plan:
- Reset: drive rst low mid-run -> same cycle dac_word=16'h8000, dac_upd=0, lock=0. Release with en=1, up=dn=0 -> dac_upd pulses every 64 clk with dac_word=16'h8000.
- Single up window: up held high from at least 3 clk before en rises, for exactly one window, then up=0 -> dac_word=16'h8440 (integ 64, prop 1024). Next window -> 16'h8040 (integ 64, prop 0).
- Both up and dn held high for 5 windows -> err=0, 5 dac_upd pulses, dac_word stays 16'h8000.
- Continuous dn -> dac_word decreases monotonically to 16'h0000 and stays there; no wrap to a high code. Integrator clamps at -2^23 under a long run.
- en dropped at count 30, up high -> no further dac_upd, dac_word held. en reasserted -> first update arrives 64+2 clk after the rising edge of en, using only the new window.
- LOOP_LOCK_DETECT_EN defined, up/dn idle -> lock rises after the 8th window. One window with up high for 10 clk -> lock falls, then re-rises after 8 further quiet windows.
